// File: rtl/axil_ram.sv
// AXI4-Lite single-port-style RAM with independent read and write channels.
// Word-addressed storage, byte-lane write strobes, read-before-write on
// same-word collisions, one outstanding B and R response per output stage.
// Optional macro AXIL_RAM_PIPELINE_OUTPUT_EN adds a registered read output
// stage (read latency 2, full throughput); default build has latency 1.
module axil_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,

  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,

  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,

  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,

  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int unsigned WORD_LSB  = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - WORD_LSB;
  localparam int unsigned WORDS     = 1 << IDX_WIDTH;

  // Storage is zero at time 0 only; reset never touches it.
  logic [DATA_WIDTH-1:0] mem [WORDS] = '{default: '0};

  logic [IDX_WIDTH-1:0] wr_idx;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic                 wr_en;
  logic                 rd_en;
  logic                 unused;

  assign wr_idx = s_axil_awaddr[ADDR_WIDTH-1:WORD_LSB];
  assign rd_idx = s_axil_araddr[ADDR_WIDTH-1:WORD_LSB];

  // Protection bits and sub-word address bits carry no meaning here.
  assign unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  // Responses are always OKAY.
  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;

  // Write accepted only with both AW and W present and room in the B stage.
  assign wr_en          = !rst && s_axil_awvalid && s_axil_wvalid &&
                          (!s_axil_bvalid || s_axil_bready);
  assign s_axil_awready = wr_en;
  assign s_axil_wready  = wr_en;

  // B channel: one response per accepted write, held until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_bvalid <= 1'b0;
    end else if (wr_en) begin
      s_axil_bvalid <= 1'b1;
    end else if (s_axil_bready) begin
      s_axil_bvalid <= 1'b0;
    end
  end

  // Byte-lane writes; NBA semantics give read-before-write on collisions.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wr_en && s_axil_wstrb[i]) begin
        mem[wr_idx][i*8 +: 8] <= s_axil_wdata[i*8 +: 8];
      end
    end
  end

`ifdef AXIL_RAM_PIPELINE_OUTPUT_EN
  logic                  stage1_valid;
  logic [DATA_WIDTH-1:0] stage1_data;
  logic                  out_ready;

  assign out_ready      = !s_axil_rvalid || s_axil_rready;
  assign s_axil_arready = !rst && (!stage1_valid || out_ready);
  assign rd_en          = s_axil_arvalid && s_axil_arready;

  // First read stage: memory access.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_valid <= 1'b0;
    end else if (rd_en) begin
      stage1_valid <= 1'b1;
    end else if (out_ready) begin
      stage1_valid <= 1'b0;
    end
  end

  // Memory read data capture for the first stage.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      stage1_data <= mem[rd_idx];
    end
  end

  // Output stage: advances whenever the R slot is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else if (out_ready) begin
      s_axil_rvalid <= stage1_valid;
      if (stage1_valid) begin
        s_axil_rdata <= stage1_data;
      end
    end
  end
`else
  assign s_axil_arready = !rst && (!s_axil_rvalid || s_axil_rready);
  assign rd_en          = s_axil_arvalid && s_axil_arready;

  // Single read stage: data registered at the accepting edge, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else if (rd_en) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= mem[rd_idx];
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end
`endif

endmodule
